// File: rtl/anc_pkg.sv
// Shared definitions for the two-microphone noise canceller.
// Holds the default sample width, the I2S receiver state encoding and the
// sample type shared by the receiver and the adaptive-filter controller.
package anc_pkg;

    localparam int DATASIZE_DEFAULT = 24;

    typedef enum logic [1:0] {
        RX_HUNT  = 2'd0,
        RX_LEFT  = 2'd1,
        RX_RIGHT = 2'd2
    } rx_state_e;

    typedef logic signed [DATASIZE_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/i2s_slot_shifter.sv
// One I2S slot deserialiser: captures up to datasize bits MSB first and
// presents them left-justified with zero-filled LSBs when the slot was short.
module i2s_slot_shifter
    import anc_pkg::*;
#(
    parameter int datasize = DATASIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck_rise,
    input  logic                sd,
    input  logic                start,
    output logic [datasize-1:0] word
);

    localparam int              CW = $clog2(datasize + 1);
    localparam logic [CW-1:0]   DS = CW'(datasize);

    logic [datasize-1:0] r_shreg;
    // Number of bits captured in the current slot, saturating at datasize.
    logic [CW-1:0]       r_count;

    // Start a slot with the MSB in bit 0, then shift in bits until the word is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (sck_rise) begin
            if (start) begin
                r_shreg <= {{(datasize-1){1'b0}}, sd};
                r_count <= CW'(1);
            end else if (r_count < DS) begin
                r_shreg <= {r_shreg[datasize-2:0], sd};
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Left-justify a short capture; a full word passes through unshifted.
    always_comb begin
        word = r_shreg << (DS - r_count);
    end

endmodule

// File: rtl/mic_pair_i2s_rx.sv
// Stereo I2S receiver for the main (left) and sub (right) microphones.
// Synchronises sck/ws/sd, tracks slots with a HUNT/LEFT/RIGHT machine and
// commits a full frame on each ws 1->0 edge, or flags an overrun when the
// filter is still busy.
// Optional feature: define MIC_RX_DC_BLOCK_EN to insert a per-channel DC
// tracker after the commit; start_sample then arrives one clk later.
module mic_pair_i2s_rx
    import anc_pkg::*;
#(
    parameter int datasize    = DATASIZE_DEFAULT,
    parameter int sync_stages = 2,
    parameter int DC_SHIFT    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck,
    input  logic                ws,
    input  logic                sd,
    input  logic                filter_busy,
    output logic [datasize-1:0] main_sample,
    output logic [datasize-1:0] sub_sample,
    output logic                start_sample,
    output logic                overrun,
    output logic                locked
);

    generate
        if (sync_stages < 2) begin : g_bad_sync
            $error("mic_pair_i2s_rx: sync_stages must be at least 2");
        end
        if (DC_SHIFT < 1) begin : g_bad_shift
            $error("mic_pair_i2s_rx: DC_SHIFT must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [sync_stages-1:0] r_sck_sync;
    logic [sync_stages-1:0] r_ws_sync;
    logic [sync_stages-1:0] r_sd_sync;
    logic                   r_sck_prev;
    logic                   w_sck_s;
    logic                   w_sck_rise;

    assign w_sck_s    = r_sck_sync[sync_stages-1];
    assign w_sck_rise = w_sck_s & ~r_sck_prev;

    // Bring the three asynchronous I2S lines into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync <= '0;
            r_ws_sync  <= '0;
            r_sd_sync  <= '0;
            r_sck_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take the old value of the one before it.
            r_sck_sync <= {r_sck_sync[sync_stages-2:0], sck};
            r_ws_sync  <= {r_ws_sync[sync_stages-2:0], ws};
            r_sd_sync  <= {r_sd_sync[sync_stages-2:0], sd};
            r_sck_prev <= w_sck_s;
        end
    end

    // Register the sck rise together with the ws/sd values it samples.
    logic r_rise;
    logic r_ws_s;
    logic r_sd_s;
    logic r_ws_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rise    <= 1'b0;
            r_ws_s    <= 1'b0;
            r_sd_s    <= 1'b0;
            r_ws_last <= 1'b0;
        end else begin
            r_rise <= w_sck_rise;
            r_ws_s <= r_ws_sync[sync_stages-1];
            r_sd_s <= r_sd_sync[sync_stages-1];
            if (r_rise) begin
                r_ws_last <= r_ws_s;
            end
        end
    end

    logic w_ws_rise;
    logic w_ws_fall;

    assign w_ws_rise = r_rise & ~r_ws_last &  r_ws_s;
    assign w_ws_fall = r_rise &  r_ws_last & ~r_ws_s;

    // ------------------------------------------------------------------
    // Slot shifters: left restarts on ws 1->0, right on ws 0->1
    // ------------------------------------------------------------------
    logic [datasize-1:0] w_left_word;
    logic [datasize-1:0] w_right_word;

    i2s_slot_shifter #(.datasize(datasize)) u_left_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck_rise (r_rise),
        .sd       (r_sd_s),
        .start    (w_ws_fall),
        .word     (w_left_word)
    );

    i2s_slot_shifter #(.datasize(datasize)) u_right_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .sck_rise (r_rise),
        .sd       (r_sd_s),
        .start    (w_ws_rise),
        .word     (w_right_word)
    );

    // ------------------------------------------------------------------
    // Slot tracking state machine
    // ------------------------------------------------------------------
    rx_state_e r_state;
    rx_state_e w_state_next;
    logic      w_lock_evt;
    logic      w_left_commit;
    logic      w_frame_commit;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: follow ws edges once the first frame boundary is found.
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            RX_HUNT:  if (w_ws_fall) w_state_next = RX_LEFT;
            RX_LEFT:  if (w_ws_rise) w_state_next = RX_RIGHT;
            RX_RIGHT: if (w_ws_fall) w_state_next = RX_LEFT;
            default:  w_state_next = RX_HUNT;
        endcase
    end

    // Decode the lock, left-commit and frame-commit events.
    always_comb begin
        w_lock_evt     = 1'b0;
        w_left_commit  = 1'b0;
        w_frame_commit = 1'b0;
        case (r_state)
            RX_HUNT:  w_lock_evt     = w_ws_fall;
            RX_LEFT:  w_left_commit  = w_ws_rise;
            RX_RIGHT: w_frame_commit = w_ws_fall;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Commit / overrun
    // ------------------------------------------------------------------
    logic [datasize-1:0] r_left_hold;
    logic                r_overrun;
    logic                r_locked;
    logic                w_accept;

    assign w_accept = w_frame_commit & ~filter_busy;

    // Hold the left word, flag drops and track lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_left_hold <= '0;
            r_overrun   <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_overrun <= w_frame_commit & filter_busy;
            if (w_lock_evt) begin
                r_locked <= 1'b1;
            end
            if (w_left_commit) begin
                r_left_hold <= w_left_word;
            end
        end
    end

    logic [datasize-1:0] r_main;
    logic [datasize-1:0] r_sub;
    logic                r_start;

`ifdef MIC_RX_DC_BLOCK_EN
    localparam int MW = datasize + DC_SHIFT;

    logic                       r_pend;
    logic signed [datasize-1:0] r_x    [2];
    logic signed [MW-1:0]       r_dc_m [2];
    logic signed [datasize:0]   w_diff [2];
    logic [datasize-1:0]        w_sat  [2];

    // Remove the tracked DC level and saturate back to datasize bits.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            // m >>> DC_SHIFT is exactly the upper datasize bits of m.
            w_diff[c] = {r_x[c][datasize-1], r_x[c]}
                      - {r_dc_m[c][MW-1], r_dc_m[c][MW-1:DC_SHIFT]};
            if (w_diff[c][datasize] != w_diff[c][datasize-1]) begin
                w_sat[c] = w_diff[c][datasize] ? {1'b1, {(datasize-1){1'b0}}}
                                               : {1'b0, {(datasize-1){1'b1}}};
            end else begin
                w_sat[c] = w_diff[c][datasize-1:0];
            end
        end
    end

    // Latch the accepted frame, then publish the DC-removed words a clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= 1'b0;
            r_start <= 1'b0;
            r_main  <= '0;
            r_sub   <= '0;
            for (int c = 0; c < 2; c++) begin
                r_x[c]    <= '0;
                r_dc_m[c] <= '0;
            end
        end else begin
            r_pend  <= w_accept;
            r_start <= r_pend;
            if (w_accept) begin
                r_x[0] <= r_left_hold;
                r_x[1] <= w_right_word;
            end
            if (r_pend) begin
                r_main <= w_sat[0];
                r_sub  <= w_sat[1];
                for (int c = 0; c < 2; c++) begin
                    r_dc_m[c] <= r_dc_m[c] + {{(DC_SHIFT-1){w_diff[c][datasize]}}, w_diff[c]};
                end
            end
        end
    end
`else
    // Publish the raw captured frame and pulse start_sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_main  <= '0;
            r_sub   <= '0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_main <= r_left_hold;
                r_sub  <= w_right_word;
            end
        end
    end
`endif

    assign main_sample  = r_main;
    assign sub_sample   = r_sub;
    assign start_sample = r_start;
    assign overrun      = r_overrun;
    assign locked       = r_locked;

endmodule

// File: tb/tb_mic_pair_i2s_rx.sv
// Self-checking bench for mic_pair_i2s_rx (default build, datasize = 24).
// A slot-level model predicts which frames commit and with what words; a
// compare process checks every pulse and the output words on every cycle.
module tb_mic_pair_i2s_rx;
    import anc_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    sck;
    logic    ws;
    logic    sd;
    logic    filter_busy;
    sample_t main_sample;
    sample_t sub_sample;
    logic    start_sample;
    logic    overrun;
    logic    locked;

    mic_pair_i2s_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .filter_busy  (filter_busy),
        .main_sample  (main_sample),
        .sub_sample   (sub_sample),
        .start_sample (start_sample),
        .overrun      (overrun),
        .locked       (locked)
    );

    // 100 MHz clk; sck is 16x slower and driven by the stimulus tasks.
    always #5 clk = ~clk;

    typedef struct packed {
        logic    busy;
        sample_t m;
        sample_t s;
    } ev_t;

    ev_t     q[$];
    int      n_tests   = 0;
    int      n_fail    = 0;
    int      n_start   = 0;
    int      n_overrun = 0;
    sample_t exp_main  = '0;
    sample_t exp_sub   = '0;

    // Slot-level model state.
    logic    m_prev_ws;
    logic    m_locked;
    logic    m_left_ok;
    logic    m_cur_ok;
    sample_t m_left_val;
    sample_t m_cur_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // What the receiver should hold after a slot of nbits bits (MSB first).
    function automatic sample_t capture(input logic [31:0] pat, input int nbits);
        int          k;
        logic [31:0] top;
        k   = (nbits < 24) ? nbits : 24;
        top = pat >> (nbits - k);
        top = top << (24 - k);
        return top[23:0];
    endfunction

    task automatic model_reset();
        m_prev_ws  = 1'b0;
        m_locked   = 1'b0;
        m_left_ok  = 1'b0;
        m_cur_ok   = 1'b0;
        m_left_val = '0;
        m_cur_val  = '0;
        q.delete();
        exp_main = '0;
        exp_sub  = '0;
    endtask

    // Called as a new slot begins: a 1->0 ws change completes the frame.
    task automatic model_slot(input logic ws_v, input sample_t cap);
        if (ws_v && !m_prev_ws) begin
            if (m_locked) begin
                m_left_val = m_cur_val;
                m_left_ok  = m_cur_ok;
            end
            m_cur_ok = m_locked;
        end else if (!ws_v && m_prev_ws) begin
            if (m_locked && m_cur_ok && m_left_ok) begin
                q.push_back('{busy: filter_busy, m: m_left_val, s: m_cur_val});
            end
            m_locked  = 1'b1;
            m_cur_ok  = 1'b1;
            m_left_ok = 1'b0;
        end
        m_prev_ws = ws_v;
        m_cur_val = cap;
    endtask

    task automatic send_bit(input logic ws_v, input logic b);
        sck = 1'b0;
        ws  = ws_v;
        sd  = b;
        #80;
        sck = 1'b1;
        #80;
    endtask

    task automatic send_slot(input logic ws_v, input logic [31:0] pat, input int nbits);
        model_slot(ws_v, capture(pat, nbits));
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit(ws_v, pat[i]);
        end
    endtask

    task automatic send_frame32(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, {l, 8'h00}, 32);
        send_slot(1'b1, {r, 8'h00}, 32);
    endtask

    task automatic do_reset(input logic ws_idle);
        sck   = 1'b0;
        sd    = 1'b0;
        ws    = ws_idle;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_main",    main_sample,  32'h0);
        check("rst_sub",     sub_sample,   32'h0);
        check("rst_start",   start_sample, 32'h0);
        check("rst_overrun", overrun,      32'h0);
        check("rst_locked",  locked,       32'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("post_rst_locked", locked, 32'h0);
    endtask

    // Compare process: pulses against the model queue, words every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b0) begin
            check("in_rst_main",   main_sample, 32'h0);
            check("in_rst_locked", locked,      32'h0);
        end else if (rst_n === 1'b1) begin
            check("pulse_exclusive", start_sample & overrun, 32'h0);
            if (start_sample || overrun) begin
                if (start_sample) n_start++;
                if (overrun)      n_overrun++;
                check("pulse_expected", (q.size() != 0), 32'h1);
                if (q.size() != 0) begin
                    ev_t e;
                    e = q.pop_front();
                    check("pulse_kind_overrun", overrun,      e.busy);
                    check("pulse_kind_start",   start_sample, !e.busy);
                    if (!e.busy) begin
                        exp_main = e.m;
                        exp_sub  = e.s;
                    end
                end
            end
            check("main_sample", main_sample, exp_main);
            check("sub_sample",  sub_sample,  exp_sub);
        end
    end

    initial begin
        int n0;
        filter_busy = 1'b0;
        do_reset(1'b0);

        // Nominal 32-bit slots: the first frame is discarded while hunting.
        repeat (4) send_frame32(24'h7FFFFF, 24'h800001);
        check("nominal_starts", n_start,     32'd2);
        check("nominal_main",   main_sample, 32'h007FFFFF);
        check("nominal_sub",    sub_sample,  32'hFF800001);
        check("nominal_locked", locked,      32'h1);

        // Busy filter during the commit of 0x123456/0x654321.
        send_frame32(24'h123456, 24'h654321);
        filter_busy = 1'b1;
        send_slot(1'b0, {24'h7FFFFF, 8'h00}, 32);
        filter_busy = 1'b0;
        send_slot(1'b1, {24'h800001, 8'h00}, 32);
        check("overrun_count",    n_overrun,   32'd1);
        check("overrun_no_start", n_start,     32'd3);
        check("overrun_hold_main", main_sample, 32'h007FFFFF);
        check("overrun_hold_sub",  sub_sample,  32'hFF800001);

        // 16-bit slots: captured bits are left-justified, LSBs zero-filled.
        send_slot(1'b0, 32'h0000ABCD, 16);
        send_slot(1'b1, 32'h00001234, 16);
        send_slot(1'b0, 32'h00005A5A, 16);
        check("short_starts", n_start,     32'd5);
        check("short_main",   main_sample, 32'hFFABCD00);
        check("short_sub",    sub_sample,  32'h00123400);

        // Reset in the middle of a RIGHT slot.
        send_slot(1'b1, 32'h000000FF, 8);
        do_reset(1'b1);
        n0 = n_start;
        send_slot(1'b1, 32'h000000F0, 8);
        check("midrst_unlocked", locked, 32'h0);
        send_frame32(24'h00FF00, 24'hFF00FF);
        check("midrst_locked",    locked,  32'h1);
        check("midrst_no_commit", n_start, n0);
        send_frame32(24'h0F0F0F, 24'h707070);
        check("midrst_one_commit", n_start,     n0 + 1);
        check("midrst_main",       main_sample, 32'h0000FF00);
        check("midrst_sub",        sub_sample,  32'hFFFF00FF);

        // Stream that starts on a right slot.
        do_reset(1'b1);
        n0 = n_start;
        send_slot(1'b1, {24'h111111, 8'h00}, 32);
        check("rfirst_unlocked", locked, 32'h0);
        send_frame32(24'h222222, 24'h333333);
        check("rfirst_no_commit", n_start, n0);
        send_slot(1'b0, {24'h444444, 8'h00}, 32);
        check("rfirst_one_commit", n_start,     n0 + 1);
        check("rfirst_main",       main_sample, 32'h00222222);
        check("rfirst_sub",        sub_sample,  32'h00333333);

        repeat (20) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
